// File: rtl/temp_conv_pkg.sv
// Shared types and constants for the temperature-conversion scheduler.
// The state encoding, the mode codes and the timeout counter width live here.
package temp_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_C   = 2'b00;
    localparam logic [1:0] MODE_F   = 2'b01;
    localparam logic [1:0] MODE_K   = 2'b10;
    localparam logic [1:0] MODE_INV = 2'b11;

    // Wide enough for any TIMEOUT in 1..31
    localparam int CNT_W = 5;

    function automatic logic mode_valid(input logic [1:0] mode);
        return mode != MODE_INV;
    endfunction

endpackage

// File: rtl/temp_conv_sched_if.sv
// Launch/complete handshake between the scheduler and the shared conversion datapath.
// The scheduler holds the master side; the datapath holds the slave side.
interface temp_conv_sched_if #(
    parameter int TW = 4,
    parameter int RW = 4
);
    logic          cv_start;
    logic [TW-1:0] cv_temp;
    logic [1:0]    cv_mode;
    logic          cv_done;
    logic [RW-1:0] cv_result;

    modport master (
        output cv_start,
        output cv_temp,
        output cv_mode,
        input  cv_done,
        input  cv_result
    );

    modport slave (
        input  cv_start,
        input  cv_temp,
        input  cv_mode,
        output cv_done,
        output cv_result
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot, combinational grant.
// prio names the channel that wins a tie; it starts at 0, so channel 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant, the channel that lost (or did not ask) gets priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (advance && (|req)) begin
            prio <= grant[0];
        end
    end
endmodule

// File: rtl/temp_conv_sched.sv
// Scheduler for the shared temperature-conversion datapath: arbitrates two channels,
// launches one conversion at a time, waits with a timeout and returns a tagged result.
//
//  state | meaning
//  IDLE  | no operation; a pending request is granted and its operands latched
//  ISSUE | ack to the granted channel; cv_start if the mode is valid
//  WAIT  | waiting for cv_done; timeout counter running
//  DONE  | res_valid pulse with the captured result or error
module temp_conv_sched
    import temp_conv_pkg::*;
#(
    parameter int            TW       = 4,
    parameter int            RW       = 4,
    parameter int            TIMEOUT  = 15,
    parameter logic [TW-1:0] GT_LIMIT = TW'(12)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [1:0]           req,
    input  logic [TW-1:0]        temp0,
    input  logic [1:0]           mode0,
    input  logic [TW-1:0]        temp1,
    input  logic [1:0]           mode1,
    output logic [1:0]           ack,
    temp_conv_sched_if.master    cv,
    output logic                 res_valid,
    output logic [RW-1:0]        res_data,
    output logic                 res_chan,
    output logic                 res_err,
    output logic                 busy,
    output logic [1:0]           over_temp,
    input  logic [1:0]           ovt_clr
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        grant;
    logic              grant_take;
    logic              chan;
    logic [TW-1:0]     op_temp;
    logic [1:0]        op_mode;
    logic [CNT_W-1:0]  cnt;
    logic              expired;
    logic [1:0]        ovt_set;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (clr),
        .req     (req),
        .advance (state == IDLE),
        .grant   (grant)
    );

    assign grant_take = (state == IDLE) && (|grant);
    assign expired    = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = 2'b00;
        cv.cv_start = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (|grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ack = chan ? 2'b10 : 2'b01;
                if (mode_valid(op_mode)) begin
                    cv.cv_start = 1'b1;
                    state_nxt   = WAIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                if (cv.cv_done || expired) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Operands stay put from the grant until the next grant
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            chan    <= 1'b0;
            op_temp <= '0;
            op_mode <= MODE_C;
        end else if (grant_take) begin
            chan    <= grant[1];
            op_temp <= grant[1] ? temp1 : temp0;
            op_mode <= grant[1] ? mode1 : mode0;
        end
    end

    assign cv.cv_temp = op_temp;
    assign cv.cv_mode = op_mode;

    // A completion that coincides with expiry still delivers its result
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            res_data <= '0;
            res_err  <= 1'b0;
            res_chan <= 1'b0;
        end else if (state == ISSUE && !mode_valid(op_mode)) begin
            res_data <= '0;
            res_err  <= 1'b1;
            res_chan <= chan;
        end else if (state == WAIT) begin
            if (cv.cv_done) begin
                res_data <= cv.cv_result;
                res_err  <= 1'b0;
                res_chan <= chan;
            end else if (expired) begin
                res_data <= '0;
                res_err  <= 1'b1;
                res_chan <= chan;
            end
        end
    end

    assign ovt_set[0] = grant_take && grant[0] && (temp0 > GT_LIMIT);
    assign ovt_set[1] = grant_take && grant[1] && (temp1 > GT_LIMIT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            over_temp <= 2'b00;
        end else begin
            over_temp <= ovt_set | (over_temp & ~ovt_clr);
        end
    end
endmodule

// File: doc/temp_conv_sched.md
Name: temp_conv_sched

Overview:
- Sequencer and arbiter for the shared temperature-conversion datapath (C/F/K adder, multiply and mux chain).
- Two sensor channels issue conversion requests. The block arbitrates round-robin, latches one channel's temperature and mode, and launches the datapath.
- It then waits for completion with a timeout, and returns a tagged, single-pulse result.
- It also tracks a sticky over-temperature flag per channel.

Parameters:
- TW, 4, temperature operand width.
- RW, 4, conversion result width.
- TIMEOUT, 15, maximum WAIT cycles before the operation is aborted (1..2^5-1).
- GT_LIMIT, 4'd12, over-temperature threshold. A channel flags when temp > GT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- req  in  2  per-channel request level; held by the requester until its ack.
- temp0  in  TW  channel 0 temperature.
- mode0  in  2  channel 0 conversion select: 00=C, 01=F, 10=K, 11=invalid.
- temp1  in  TW  channel 1 temperature.
- mode1  in  2  channel 1 conversion select.
- ack  out  2  one-hot, one-cycle pulse: request accepted, operands latched.
- cv_start  out  1  one-cycle launch pulse to the datapath.
- cv_temp  out  TW  latched operand, stable from ISSUE until return to IDLE.
- cv_mode  out  2  latched mode, stable as cv_temp.
- cv_done  in  1  datapath completion strobe.
- cv_result  in  RW  datapath result; valid while cv_done=1.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  RW  result; holds its value until the next res_valid.
- res_chan  out  1  channel that owns res_data.
- res_err  out  1  qualifies res_data: timeout or invalid mode.
- busy  out  1  high in every state except IDLE.
- over_temp  out  2  sticky per-channel over-temperature flags.
- ovt_clr  in  2  per-channel clear for over_temp.

Behaviour:
- Reset (clr=0, async): state=IDLE, rr pointer=0, timeout counter=0. All outputs are 0, including res_data, over_temp, cv_temp and cv_mode. A reset mid-operation abandons the operation. A later cv_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set at a clock edge, the FSM grants and moves to ISSUE.
  - Operands of the granted channel are latched at that edge.
  - ack[granted] is high throughout the ISSUE cycle.
- Arbitration:
  - Single request: that channel is granted.
  - Both channels requesting: the channel that is not the last granted wins.
  - The last-granted pointer updates on each grant and resets to 1, so ch0 wins the first tie.
- ISSUE:
  - Valid mode: cv_start=1 for exactly this cycle, next state WAIT.
  - mode=11: cv_start stays 0, next state DONE with res_err=1 and res_data=0.
- WAIT:
  - The counter increments every cycle.
  - cv_done=1: capture cv_result into res_data, res_err=0, go to DONE.
  - No cv_done and counter==TIMEOUT-1: res_data=0, res_err=1, go to DONE.
  - cv_done in the same cycle as the expiry wins, and the result is taken.
- DONE: res_valid=1, res_chan set, for this cycle only. Next state IDLE and the counter clears. No grant is made in DONE.
- Latency: grant edge to res_valid is minimum 3 cycles (cv_done in the first WAIT cycle). Maximum is TIMEOUT+2 cycles.
- Throughput: at most one conversion per 4 cycles.
- cv_done outside WAIT is ignored.
- A req bit dropped before its ack: only the IDLE edge samples req, so no effect.
- Over-temperature:
  - At the grant edge, if the latched temp > GT_LIMIT, over_temp[ch] is set.
  - The flag is cleared by ovt_clr[ch].
  - Simultaneous set and clear on the same channel: set wins.
  - The flag is independent of mode validity.

Decomposition:
- Package temp_conv_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - mode constants (MODE_C=2'b00, MODE_F=2'b01, MODE_K=2'b10, MODE_INV=2'b11).
- One sub-module: rr_arb2, the 2-requester round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot grant.
  - Keeps its last-grant register internally.
- The FSM, timeout counter, operand and result registers, and over_temp live in the top.

Test Plan:
- Single request: req=01, temp0=4'd5, mode0=01, cv_done 1 cycle after cv_start with result 4'd5. Expect:
  - ack=01 in cycle 1;
  - cv_start in cycle 1;
  - res_valid in cycle 3 with res_data=5, res_chan=0, res_err=0.
- Tie and fairness:
  - req=11 held from reset → grants ch0, then ch1, then ch0.
  - Each res_chan matches its grant.
  - Operands of the non-granted channel never appear on cv_temp.
- Timeout: TIMEOUT=15, cv_done never asserted. Expect res_valid exactly 17 cycles after the grant edge with res_err=1 and res_data=0. A cv_done asserted afterward is ignored.
- Invalid mode: req=10, mode1=11. Expect cv_start never pulses, res_valid 2 cycles after the grant with res_err=1 and res_chan=1.
- Over-temperature:
  - temp0=4'd13 → over_temp[0]=1 after the grant and held through later grants with temp0=4'd3.
  - ovt_clr=01 asserted together with a new grant at temp0=13 → over_temp[0] stays 1.
  - temp0=12 → never sets the flag.
- Reset mid-WAIT: assert clr=0 during WAIT → busy, res_valid and over_temp drop to 0 immediately. After release, a stale cv_done produces no res_valid.
